// File: rtl/fb_pkg.sv
// Shared constants, types and state encoding for the frame-buffer scanout arbiter.
package fb_pkg;

   localparam int FB_W       = 160;
   localparam int FB_H       = 120;
   localparam int SCALE_LOG2 = 2;
   localparam int PIX_W      = 8;
   localparam int ADDR_W     = 15;
   localparam int FB_WORDS   = FB_W * FB_H;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [PIX_W-1:0]  pix_t;

   typedef enum logic {
      IDLE,
      CLEAR
   } arb_state_t;

endpackage

// File: rtl/vga_pipe_delay.sv
// Two-stage delay for the timing-generator sync and visible-area flags, so they
// line up with pixels that take two cycles to come back from the frame buffer.
module vga_pipe_delay (
   input  logic clk,
   input  logic reset,
   input  logic hsync,
   input  logic vsync,
   input  logic valid,
   output logic hsync_d,
   output logic vsync_d,
   output logic de_d
);

   logic hsync_s1;
   logic vsync_s1;
   logic de_s1;

   // Syncs are active-low, so both stages idle high out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hsync_s1 <= 1'b1;
         vsync_s1 <= 1'b1;
         de_s1    <= 1'b0;
         hsync_d  <= 1'b1;
         vsync_d  <= 1'b1;
         de_d     <= 1'b0;
      end else begin
         hsync_s1 <= hsync;
         vsync_s1 <= vsync;
         de_s1    <= valid;
         hsync_d  <= hsync_s1;
         vsync_d  <= vsync_s1;
         de_d     <= de_s1;
      end
   end

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Shares one single-port frame-buffer RAM between VGA scanout (never stalled),
// a handshaked pixel writer and a full-frame clear engine; upscales pixels 4x.
module fb_scanout_arbiter
   import fb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [9:0]        curr_col,
   input  logic [9:0]        curr_row,
   input  logic              HSYNC,
   input  logic              VSYNC,
   input  logic              valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   output logic              wr_ack,
   input  logic              clear_start,
   input  logic [PIX_W-1:0]  clear_color,
   output logic              clear_busy,
   output logic              clear_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [PIX_W-1:0]  mem_wdata,
   input  logic [PIX_W-1:0]  mem_rdata,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              de_out,
   output logic [PIX_W-1:0]  rgb_out
);

   arb_state_t state;
   arb_state_t next_state;

   logic [9:0] fb_row;
   logic [9:0] fb_col;
   addr_t      scan_addr;
   logic       scan_slot;
   logic       scan_slot_q;
   pix_t       hold;

   addr_t      clear_cnt;
   pix_t       clear_col;
   logic       clear_write;
   logic       clear_last;
   logic       wr_in_range;

   // Only the first column of each 4-wide pixel needs a RAM read; the other
   // three cycles of the group are free for the writer or the clear engine.
   assign fb_row      = curr_row >> SCALE_LOG2;
   assign fb_col      = curr_col >> SCALE_LOG2;
   assign scan_slot   = valid && (curr_col[SCALE_LOG2-1:0] == '0);
   assign scan_addr   = addr_t'({fb_row, 7'd0}) + addr_t'({fb_row, 5'd0}) + addr_t'(fb_col);

   assign wr_in_range = (wr_addr < addr_t'(FB_WORDS));
   assign clear_last  = (clear_cnt == addr_t'(FB_WORDS - 1));
   assign clear_busy  = (state == CLEAR);

   // Port mux: scanout owns the RAM during its slot, otherwise the state picks
   // the writer or the clear engine. Grants are held off while reset is high.
   always_comb begin
      next_state  = state;
      wr_ack      = 1'b0;
      mem_we      = 1'b0;
      mem_addr    = scan_addr;
      mem_wdata   = clear_col;
      clear_write = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               if (wr_req && !scan_slot) begin
                  wr_ack = 1'b1;
                  if (wr_in_range) begin
                     mem_we    = 1'b1;
                     mem_addr  = wr_addr;
                     mem_wdata = wr_data;
                  end
               end
               if (clear_start) begin
                  next_state = CLEAR;
               end
            end
            CLEAR: begin
               if (!scan_slot) begin
                  clear_write = 1'b1;
                  mem_we      = 1'b1;
                  mem_addr    = clear_cnt;
                  mem_wdata   = clear_col;
                  if (clear_last) begin
                     next_state = IDLE;
                  end
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Clear engine bookkeeping; the fill colour is captured only on acceptance.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clear_cnt  <= '0;
         clear_col  <= '0;
         clear_done <= 1'b0;
      end else begin
         clear_done <= clear_write && clear_last;
         if (state == IDLE && clear_start) begin
            clear_col <= clear_color;
            clear_cnt <= '0;
         end else if (clear_write) begin
            clear_cnt <= clear_cnt + 1'b1;
         end
      end
   end

   // Read data returns one cycle after the slot; hold it for the whole group.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         scan_slot_q <= 1'b0;
         hold        <= '0;
      end else begin
         scan_slot_q <= scan_slot;
         if (scan_slot_q) begin
            hold <= mem_rdata;
         end
      end
   end

   assign rgb_out = de_out ? hold : '0;

   vga_pipe_delay u_pipe (
      .clk     (clk),
      .reset   (reset),
      .hsync   (HSYNC),
      .vsync   (VSYNC),
      .valid   (valid),
      .hsync_d (hsync_out),
      .vsync_d (vsync_out),
      .de_d    (de_out)
   );

endmodule

// File: doc/fb_scanout_arbiter.md
Name: fb_scanout_arbiter

Overview:
- Shares one single-port frame-buffer RAM (160x120, 8-bit pixels) between three users: VGA scanout, a game-logic pixel writer, and a built-in frame-clear engine.
- Sits between the 640x480 timing generator and the pixel output pins. Each stored pixel is upscaled 4x in both directions.
- Delays the sync and visible-area signals by 2 cycles so they stay aligned with the fetched pixel data.

Parameters:
- FB_W, 160, frame-buffer width in pixels.
- FB_H, 120, frame-buffer height in pixels.
- SCALE_LOG2, 2, log2 of the upscale factor; one stored pixel covers 4x4 screen pixels.
- PIX_W, 8, pixel/colour width in bits.
- ADDR_W, 15, RAM address width; must satisfy FB_W*FB_H <= 2^ADDR_W.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  asynchronous, active-high reset.
- curr_col  in  10  column count from the timing generator; 0 is the first visible pixel.
- curr_row  in  10  row count from the timing generator.
- HSYNC  in  1  horizontal sync from the timing generator.
- VSYNC  in  1  vertical sync from the timing generator.
- valid  in  1  visible-area flag from the timing generator.
- wr_req  in  1  writer request; held with wr_addr/wr_data until acked.
- wr_addr  in  ADDR_W  writer RAM address.
- wr_data  in  PIX_W  writer pixel value.
- wr_ack  out  1  combinational grant; a write transfers on the edge where wr_req&&wr_ack.
- clear_start  in  1  single-cycle pulse requesting a full-frame clear.
- clear_color  in  PIX_W  fill value; sampled when clear_start is accepted.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse after the last clear write.
- mem_addr  out  ADDR_W  RAM address (combinational).
- mem_we  out  1  RAM write enable (combinational).
- mem_wdata  out  PIX_W  RAM write data.
- mem_rdata  in  PIX_W  RAM read data; synchronous, 1-cycle latency.
- hsync_out  out  1  HSYNC delayed 2 cycles.
- vsync_out  out  1  VSYNC delayed 2 cycles.
- de_out  out  1  valid delayed 2 cycles.
- rgb_out  out  PIX_W  pixel to DAC; 0 when de_out=0.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset).
- Reset values:
  - hsync_out=1, vsync_out=1, de_out=0, rgb_out=0.
  - clear_busy=0, clear_done=0, mem_we=0, wr_ack=0.
  - State IDLE, clear counter 0, pixel hold register 0.
- Scan slot: scan_slot = valid && curr_col[1:0]==0. This is the highest priority use of the RAM and is never stalled.
  - mem_addr = (curr_row>>2)*FB_W + (curr_col>>2). Implement as shift-add: r*128 + r*32.
  - mem_we=0 during a scan slot.
- Scan latency: slot in cycle t; mem_rdata valid in t+1; hold register loads at the end of t+1.
  - rgb_out = de_out ? hold : 0.
  - Each fetched pixel is therefore shown for 4 consecutive outputs starting at t+2.
  - hsync_out, vsync_out and de_out come through a 2-stage register delay, so they align with rgb_out.
- States IDLE and CLEAR.
- IDLE:
  - wr_ack = wr_req && !scan_slot.
  - When wr_ack=1: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
  - clear_start → CLEAR next cycle: latch clear_color, counter=0.
  - clear_start and a granted write in the same cycle: the write completes, then the clear starts.
- CLEAR:
  - clear_busy=1 and wr_ack=0.
  - Each !scan_slot cycle: write the latched colour to address counter, then increment the counter.
  - After writing address FB_W*FB_H-1: go to IDLE, pulse clear_done for 1 cycle, clear_busy=0 in that same cycle.
  - clear_start is ignored while in CLEAR.
- Blanking (valid=0): every cycle is free for the writer or the clear engine.
- Out-of-range wr_addr (>= FB_W*FB_H): still acked, but the write is dropped (mem_we=0).
- Reset mid-clear abandons the clear: no clear_done pulse, RAM contents are undefined.

Decomposition:
- Package fb_pkg:
  - Constants FB_W, FB_H, SCALE_LOG2, PIX_W, ADDR_W, FB_WORDS=FB_W*FB_H.
  - Typedefs addr_t and pix_t.
  - Enum arb_state_t {IDLE, CLEAR}.
- Sub-module vga_pipe_delay: a 2-stage register pipeline for HSYNC/VSYNC/valid, with reset values 1/1/0.

Test Plan:
- Reset: assert reset mid-line → hsync_out=1, vsync_out=1, de_out=0, rgb_out=0, mem_we=0, clear_busy=0 immediately, without waiting for a clock edge.
- Scanout: preload RAM[0]=0x11, RAM[1]=0x22, RAM[160]=0x33 → at row0 the outputs for cols 0-3 are 0x11 and cols 4-7 are 0x22; at row4 col0 the output is 0x33; at row480 de_out=0 and rgb_out=0.
- Arbitration: hold wr_req with wr_addr=5, wr_data=0xAA arriving at row0 col4 → wr_ack=0 at col4 and wr_ack=1 at col5, with mem_we=1, mem_addr=5; a later scan of col20-23 shows 0xAA.
- Clear: clear_start with colour 0x3C at row481 → clear_busy rises next cycle, exactly 19200 writes occur, clear_done pulses once, and wr_req is not acked during the clear; RAM is all 0x3C afterwards.
- Reset mid-clear: assert reset when the counter reaches 100 → busy=0 and no done pulse; a new clear_start restarts at address 0.
- Sync alignment: HSYNC low for cols 656-751 → hsync_out low for exactly 96 cycles, starting 2 cycles later; VSYNC rows 490-491 are delayed the same way.
